// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, TRAP} state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the latched instruction register into fields and class flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [25:0] jidx,
  output logic [31:0] imm_ext,
  output alu_op_t     alu_op,
  output logic        alu_src_imm,
  output logic        illegal,
  output logic        is_branch,
  output logic        is_jump,
  output logic        reg_dst_rd,
  output logic        is_arith,
  output logic        writes_reg
);
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign jidx    = ir[25:0];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    reg_dst_rd  = 1'b0;
    is_arith    = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        reg_dst_rd = 1'b1;
        case (ir[5:0])
          FN_ADD:  is_arith = 1'b1;
          FN_SUB: begin alu_op = ALU_SUB; is_arith = 1'b1; end
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          default: begin illegal = 1'b1; reg_dst_rd = 1'b0; end
        endcase
      end
      OP_ADDI: begin alu_src_imm = 1'b1; is_arith = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; is_branch = 1'b1; end
      OP_J:    is_jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  assign writes_reg = reg_dst_rd | alu_src_imm;
endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with a sticky TRAP state.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [31:0] pc_q,
  input  logic        f_zero,
  input  logic        f_overflow,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  output logic [4:0]  write_reg,
  output logic        write,
  output logic        inc,
  output logic        ld,
  output logic [31:0] pc_target,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic        err
);
  if (PC_STEP != 4) begin : g_step_chk
    $error("control_unit assumes a 4-byte PC step");
  end

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [4:0]  rs, rt, rd;
  logic [25:0] jidx;
  alu_op_t     dec_alu_op;
  logic        illegal, is_branch, is_jump, reg_dst_rd, is_arith, writes_reg;

  instr_decoder u_dec (
    .ir          (ir_q),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .jidx        (jidx),
    .imm_ext     (imm_ext),
    .alu_op      (dec_alu_op),
    .alu_src_imm (alu_src_imm),
    .illegal     (illegal),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .reg_dst_rd  (reg_dst_rd),
    .is_arith    (is_arith),
    .writes_reg  (writes_reg)
  );

  // Fields come straight from ir, so they stay stable for the whole instruction.
  assign read_reg_1  = rs;
  assign read_reg_2  = rt;
  assign write_reg   = reg_dst_rd ? rd : (writes_reg ? rt : 5'd0);
  assign alu_op      = dec_alu_op;
  assign instr_ready = (state_q == FETCH);
  assign err         = (state_q == TRAP);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    inc       = 1'b0;
    ld        = 1'b0;
    write     = 1'b0;
    pc_target = 32'h0;
    case (state_q)
      FETCH: if (instr_valid) begin
        ir_d    = instr;
        inc     = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (illegal) state_d = TRAP;
        else if (is_jump) begin
          ld        = 1'b1;
          pc_target = {pc_q[31:28], jidx, 2'b00};
          state_d   = FETCH;
        end else state_d = EXECUTE;
      end
      EXECUTE: state_d = WRITEBACK;
      WRITEBACK: begin
        if (is_arith && f_overflow) state_d = TRAP;
        else begin
          write = writes_reg && (write_reg != 5'd0);
          if (is_branch && f_zero) begin
            ld        = 1'b1;
            pc_target = pc_q + {imm_ext[29:0], 2'b00};
          end
          state_d = FETCH;
        end
      end
      default: state_d = TRAP;
    endcase
    // A cycle with clr asserted must not leave any side effect behind.
    if (clr) begin
      inc   = 1'b0;
      ld    = 1'b0;
      write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= FETCH;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// Table-driven and randomized checks of control_unit against a behavioural instruction model.
module tb_control_unit;
  logic        clk = 1'b0;
  logic        clr, instr_valid, f_zero, f_overflow;
  logic [31:0] instr, pc_q;
  logic        instr_ready, write, inc, ld, alu_src_imm, err;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [31:0] pc_target, imm_ext;
  logic [1:0]  alu_op;

  control_unit #(.PC_STEP(4)) dut (
    .clk(clk), .clr(clr), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .pc_q(pc_q), .f_zero(f_zero), .f_overflow(f_overflow),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .write_reg(write_reg),
    .write(write), .inc(inc), .ld(ld), .pc_target(pc_target), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .imm_ext(imm_ext), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_ILL = 3'd0, K_R = 3'd1, K_ADDI = 3'd2, K_BEQ = 3'd3, K_J = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [1:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic        wen;
    logic        ld;
    logic [31:0] target;
    logic        trap;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fz;
    logic        fo;
    exp_t        e;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: what an instruction should do, from the ISA rules alone.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                 input logic fz, input logic fo);
    exp_t e;
    logic arith;
    e     = '0;
    arith = 1'b0;
    e.rr1 = i[25:21];
    e.rr2 = i[20:16];
    e.imm = {{16{i[15]}}, i[15:0]};
    e.kind = K_ILL;
    if (i[31:26] == 6'h00) begin
      e.wr = i[15:11];
      if (i[5:0] == 6'h20) begin e.kind = K_R; e.alu = 2'd0; arith = 1'b1; end
      if (i[5:0] == 6'h22) begin e.kind = K_R; e.alu = 2'd1; arith = 1'b1; end
      if (i[5:0] == 6'h24) begin e.kind = K_R; e.alu = 2'd2; end
      if (i[5:0] == 6'h25) begin e.kind = K_R; e.alu = 2'd3; end
    end else if (i[31:26] == 6'h08) begin
      e.kind = K_ADDI; e.wr = i[20:16]; e.src = 1'b1; arith = 1'b1;
    end else if (i[31:26] == 6'h04) begin
      e.kind = K_BEQ; e.alu = 2'd1; e.ld = fz;
      e.target = pc + e.imm * 32'd4;
    end else if (i[31:26] == 6'h02) begin
      e.kind = K_J; e.ld = 1'b1;
      e.target = (pc & 32'hF000_0000) + {6'b0, i[25:0]} * 32'd4;
    end
    e.trap = (e.kind == K_ILL) || (arith && fo);
    e.wen  = (e.kind == K_R || e.kind == K_ADDI) && !e.trap && (e.wr != 5'd0);
    return e;
  endfunction

  task automatic trap_check();
    chk("trap_err", {31'b0, err}, 1);
    chk("trap_ready", {31'b0, instr_ready}, 0);
    chk("trap_write", {31'b0, write}, 0);
    instr_valid = 1'b1;
    instr = 32'h00221820;
    repeat (3) begin
      @(negedge clk); #1;
      chk("trap_hold_ready", {31'b0, instr_ready}, 0);
      chk("trap_hold_inc", {31'b0, inc}, 0);
      chk("trap_hold_err", {31'b0, err}, 1);
    end
    instr_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; #1;
    chk("trap_clr_ready", {31'b0, instr_ready}, 1);
    chk("trap_clr_err", {31'b0, err}, 0);
  endtask

  task automatic exec(input logic [31:0] i, input logic [31:0] pc,
                      input logic fz, input logic fo, input exp_t e);
    @(negedge clk);
    f_zero = 1'b0; f_overflow = 1'b0;
    #1 chk("idle_ready", {31'b0, instr_ready}, 1);
    instr = i; pc_q = pc; instr_valid = 1'b1;
    #1;
    chk("accept_inc", {31'b0, inc}, 1);
    chk("accept_ld", {31'b0, ld}, 0);
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom(); #1;
    chk("dec_rr1", {27'b0, read_reg_1}, {27'b0, e.rr1});
    chk("dec_rr2", {27'b0, read_reg_2}, {27'b0, e.rr2});
    chk("dec_ready", {31'b0, instr_ready}, 0);
    chk("dec_inc", {31'b0, inc}, 0);
    if (e.kind == K_J) begin
      chk("j_ld", {31'b0, ld}, 1);
      chk("j_target", pc_target, e.target);
      @(negedge clk); #1;
      chk("j_ready", {31'b0, instr_ready}, 1);
      chk("j_ld_off", {31'b0, ld}, 0);
      return;
    end
    chk("dec_ld", {31'b0, ld}, 0);
    if (e.kind == K_ILL) begin
      @(negedge clk); #1;
      trap_check();
      return;
    end
    @(negedge clk); #1;
    chk("ex_alu", {30'b0, alu_op}, {30'b0, e.alu});
    chk("ex_src", {31'b0, alu_src_imm}, {31'b0, e.src});
    chk("ex_imm", imm_ext, e.imm);
    chk("ex_write", {31'b0, write}, 0);
    chk("ex_rr1", {27'b0, read_reg_1}, {27'b0, e.rr1});
    @(negedge clk);
    f_zero = fz; f_overflow = fo; #1;
    chk("wb_write", {31'b0, write}, {31'b0, e.wen});
    if (e.kind == K_R || e.kind == K_ADDI)
      chk("wb_wreg", {27'b0, write_reg}, {27'b0, e.wr});
    chk("wb_ld", {31'b0, ld}, {31'b0, e.ld});
    if (e.ld) chk("wb_target", pc_target, e.target);
    chk("wb_alu", {30'b0, alu_op}, {30'b0, e.alu});
    chk("wb_inc", {31'b0, inc}, 0);
    @(negedge clk);
    f_zero = 1'b0; f_overflow = 1'b0; #1;
    if (e.trap) trap_check();
    else begin
      chk("done_ready", {31'b0, instr_ready}, 1);
      chk("done_err", {31'b0, err}, 0);
      chk("done_write", {31'b0, write}, 0);
    end
  endtask

  vec_t tbl[14];

  initial begin
    // kind, rr1, rr2, wr, alu, src, imm, wen, ld, target, trap
    tbl[0]  = '{32'h00221820, 32'h0, 1'b0, 1'b0, '{K_R, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 32'h00001820, 1'b1, 1'b0, 32'h0, 1'b0}};
    tbl[1]  = '{32'h20050007, 32'h0, 1'b0, 1'b0, '{K_ADDI, 5'd0, 5'd5, 5'd5, 2'd0, 1'b1, 32'h00000007, 1'b1, 1'b0, 32'h0, 1'b0}};
    tbl[2]  = '{32'h2000FFFF, 32'h0, 1'b0, 1'b0, '{K_ADDI, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b0}};
    tbl[3]  = '{32'h10220003, 32'h104, 1'b1, 1'b0, '{K_BEQ, 5'd1, 5'd2, 5'd0, 2'd1, 1'b0, 32'h00000003, 1'b0, 1'b1, 32'h110, 1'b0}};
    tbl[4]  = '{32'h10220003, 32'h104, 1'b0, 1'b0, '{K_BEQ, 5'd1, 5'd2, 5'd0, 2'd1, 1'b0, 32'h00000003, 1'b0, 1'b0, 32'h0, 1'b0}};
    tbl[5]  = '{32'h08000040, 32'h40000004, 1'b0, 1'b0, '{K_J, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 32'h00000040, 1'b0, 1'b1, 32'h40000100, 1'b0}};
    tbl[6]  = '{32'h00222022, 32'h0, 1'b0, 1'b0, '{K_R, 5'd1, 5'd2, 5'd4, 2'd1, 1'b0, 32'h00002022, 1'b1, 1'b0, 32'h0, 1'b0}};
    tbl[7]  = '{32'h00223024, 32'h0, 1'b0, 1'b0, '{K_R, 5'd1, 5'd2, 5'd6, 2'd2, 1'b0, 32'h00003024, 1'b1, 1'b0, 32'h0, 1'b0}};
    tbl[8]  = '{32'h00223825, 32'h0, 1'b0, 1'b0, '{K_R, 5'd1, 5'd2, 5'd7, 2'd3, 1'b0, 32'h00003825, 1'b1, 1'b0, 32'h0, 1'b0}};
    tbl[9]  = '{32'h1000FFFF, 32'h0, 1'b1, 1'b0, '{K_BEQ, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0}};
    tbl[10] = '{32'h00221820, 32'h0, 1'b0, 1'b1, '{K_R, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 32'h00001820, 1'b0, 1'b0, 32'h0, 1'b1}};
    tbl[11] = '{32'hFC000000, 32'h0, 1'b0, 1'b0, '{K_ILL, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1}};
    tbl[12] = '{32'h00223024, 32'h0, 1'b0, 1'b1, '{K_R, 5'd1, 5'd2, 5'd6, 2'd2, 1'b0, 32'h00003024, 1'b1, 1'b0, 32'h0, 1'b0}};
    tbl[13] = '{32'h00221820, 32'h0, 1'b0, 1'b0, '{K_R, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 32'h00001820, 1'b1, 1'b0, 32'h0, 1'b0}};

    clr = 1'b1; instr_valid = 1'b0; instr = 32'h0; pc_q = 32'h0;
    f_zero = 1'b0; f_overflow = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'b0, instr_ready}, 1);
    chk("rst_inc", {31'b0, inc}, 0);
    chk("rst_ld", {31'b0, ld}, 0);
    chk("rst_write", {31'b0, write}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_rr1", {27'b0, read_reg_1}, 0);
    chk("rst_rr2", {27'b0, read_reg_2}, 0);
    chk("rst_wreg", {27'b0, write_reg}, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_alu", {30'b0, alu_op}, 0);
    chk("rst_src", {31'b0, alu_src_imm}, 0);
    chk("rst_imm", imm_ext, 0);
    clr = 1'b0;

    for (int k = 0; k < 14; k++)
      exec(tbl[k].instr, tbl[k].pc, tbl[k].fz, tbl[k].fo, tbl[k].e);

    // clr during EXECUTE of an add: instruction abandoned without a write.
    @(negedge clk);
    instr = 32'h00221820; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1; #1;
    chk("clr_ex_write", {31'b0, write}, 0);
    @(negedge clk);
    clr = 1'b0; #1;
    chk("clr_ex_ready", {31'b0, instr_ready}, 1);
    chk("clr_ex_err", {31'b0, err}, 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("clr_ex_nowrite", {31'b0, write}, 0);
      chk("clr_ex_idle", {31'b0, instr_ready}, 1);
    end
    exec(32'h00221820, 32'h0, 1'b0, 1'b0, model(32'h00221820, 32'h0, 1'b0, 1'b0));

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ri, rpc;
      logic        rz, ro;
      logic [5:0]  fn;
      case ($urandom_range(0, 3))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        default: fn = 6'h25;
      endcase
      ri = $urandom();
      case ($urandom_range(0, 5))
        0: ri = {6'h00, ri[25:6], fn};
        1: ri = {6'h08, ri[25:0]};
        2: ri = {6'h04, ri[25:0]};
        3: ri = {6'h02, ri[25:0]};
        4: ri = {6'h00, ri[25:0]};
        default: ;
      endcase
      rpc = $urandom();
      rz  = 1'($urandom_range(0, 1));
      ro  = ($urandom_range(0, 3) == 0);
      exec(ri, rpc, rz, ro, model(ri, rpc, rz, ro));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
